// File: rtl/riscv_pkg.sv
// Shared RV32 fetch types: word widths, default boot address and the queue entry layout.
package riscv_pkg;

    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

    // Fetch addresses are always word aligned; the low two bits are dropped.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Bundle of the fetch queue's memory, consumer and redirect signals.
interface fetch_queue_if
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [XLEN-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [XLEN-1:0]    out_pc;
    logic               redirect;
    logic [XLEN-1:0]    redirect_pc;
    logic [CNT_W-1:0]   count;

    modport master (
        output imem_addr,
        input  imem_data,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc,
        input  redirect,
        input  redirect_pc,
        output count
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc,
        output redirect,
        output redirect_pc,
        input  count
    );

endinterface

// File: rtl/fetch_queue_sync_fifo.sv
// Register-based circular FIFO with flush; head entry is readable combinationally from storage.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;
    logic [DEPTH-1:0] entry_we;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    // A pop never frees a slot for a push in the same cycle: full blocks the push outright.
    assign do_push = push && !flush && !full;
    assign do_pop  = pop  && !flush && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
            else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
            assign entry_we[gi] = do_push && (wr_ptr_q == PTR_W'(gi));
        end
    endgenerate

    // Storage is cleared on reset so the head reads zero until the first push.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (entry_we[i]) mem_q[i] <= wr_data;
            end
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: sequential PC generation into a FIFO, flushed and restarted on redirect.
module fetch_queue
    import riscv_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic         clk,
    input  logic         rst,
    fetch_queue_if.master bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] fifo_count;
    fetch_entry_t     wr_entry;
    fetch_entry_t     rd_entry;

    // Redirect wins over everything except reset; it discards the queue and suppresses push/pop.
    always_comb begin
        push           = !full && !bus.redirect;
        pop            = !empty && bus.out_ready && !bus.redirect;
        wr_entry.pc    = fetch_pc_q;
        wr_entry.instr = bus.imem_data;
        fetch_pc_d     = fetch_pc_q;
        if (bus.redirect)  fetch_pc_d = align_pc(bus.redirect_pc);
        else if (push)     fetch_pc_d = fetch_pc_q + 32'd4;
    end

    always_ff @(posedge clk) begin
        if (rst) fetch_pc_q <= RESET_PC;
        else     fetch_pc_q <= fetch_pc_d;
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .flush   (bus.redirect),
        .wr_data (wr_entry),
        .rd_data (rd_entry),
        .count   (fifo_count),
        .full    (full),
        .empty   (empty)
    );

    assign bus.imem_addr = fetch_pc_q;
    assign bus.out_valid = !empty;
    assign bus.out_instr = rd_entry.instr;
    assign bus.out_pc    = rd_entry.pc;
    assign bus.count     = fifo_count;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus random traffic against a queue model.
module tb_fetch_queue;
    import riscv_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] salt;
    bit          chk_en  = 1'b0;
    bit          verbose = 1'b1;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    fetch_queue_if #(.DEPTH(DEPTH)) bus();

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    // Instruction memory: word index XOR a per-phase salt, combinational.
    assign bus.imem_data = (bus.imem_addr >> 2) ^ salt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h, expected %08h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of (pc, instr) pairs and a fetch address.
    logic [31:0] m_pcs[$];
    logic [31:0] m_ins[$];
    logic [31:0] m_pc;

    always @(posedge clk) begin : model
        bit do_pop;
        bit do_push;
        if (rst) begin
            m_pcs.delete();
            m_ins.delete();
            m_pc = 32'h0;
        end else if (bus.redirect) begin
            m_pcs.delete();
            m_ins.delete();
            m_pc = bus.redirect_pc & 32'hFFFF_FFFC;
        end else begin
            do_pop  = (m_pcs.size() > 0) && bus.out_ready;
            do_push = (m_pcs.size() < DEPTH);
            if (do_pop) begin
                if (verbose) $display("pop  pc=%08h instr=%08h", m_pcs[0], m_ins[0]);
                void'(m_pcs.pop_front());
                void'(m_ins.pop_front());
            end
            if (do_push) begin
                m_pcs.push_back(m_pc);
                m_ins.push_back((m_pc >> 2) ^ salt);
                m_pc = m_pc + 32'd4;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("count", 32'(bus.count), 32'(m_pcs.size()));
            chk("out_valid", 32'(bus.out_valid), 32'(m_pcs.size() != 0));
            chk("imem_addr", bus.imem_addr, m_pc);
            if (m_pcs.size() != 0) begin
                chk("out_pc", bus.out_pc, m_pcs[0]);
                chk("out_instr", bus.out_instr, m_ins[0]);
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [31:0] a0;
        rst = 1'b1;
        bus.out_ready   = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        salt = 32'h0;
        step(2);
        $display("scenario reset state");
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_addr", bus.imem_addr, 32'h0);
        chk("rst_out_pc", bus.out_pc, 32'h0);
        chk("rst_out_instr", bus.out_instr, 32'h0);
        chk_en = 1'b1;
        rst = 1'b0;

        $display("scenario fill after reset");
        step(4);
        chk("fill_count", 32'(bus.count), 32'd4);
        chk("fill_addr", bus.imem_addr, 32'd16);
        chk("fill_head_pc", bus.out_pc, 32'd0);
        chk("fill_head_instr", bus.out_instr, 32'd0);
        step(1);
        chk("full_addr_hold", bus.imem_addr, 32'd16);

        $display("scenario steady drain");
        bus.out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step(1);
            chk("drain_pc", bus.out_pc, 32'(4 * (k + 1)));
        end
        chk("drain_count", 32'(bus.count), 32'd3);
        bus.out_ready = 1'b0;
        step(1);
        chk("refill_count", 32'(bus.count), 32'd4);

        $display("scenario single pop from full");
        a0 = bus.imem_addr;
        bus.out_ready = 1'b1;
        step(1);
        bus.out_ready = 1'b0;
        chk("pop_full_count", 32'(bus.count), 32'd3);
        chk("pop_full_addr", bus.imem_addr, a0);
        step(1);
        chk("repush_count", 32'(bus.count), 32'd4);
        chk("repush_addr", bus.imem_addr, a0 + 32'd4);

        $display("scenario redirect at count 3");
        bus.out_ready = 1'b1;
        step(1);
        chk("pre_redir_count", 32'(bus.count), 32'd3);
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h0000_0103;
        step(1);
        bus.redirect = 1'b0;
        chk("redir_count", 32'(bus.count), 32'd0);
        chk("redir_valid", 32'(bus.out_valid), 32'd0);
        chk("redir_addr", bus.imem_addr, 32'h100);
        step(1);
        bus.out_ready = 1'b0;
        chk("redir_head_pc", bus.out_pc, 32'h100);
        chk("redir_head_instr", bus.out_instr, 32'h40);

        $display("scenario reset overrides redirect");
        step(1);
        chk("pre_rst_count", 32'(bus.count), 32'd2);
        rst = 1'b1;
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h0000_0200;
        step(1);
        rst = 1'b0;
        bus.redirect = 1'b0;
        chk("rst_redir_count", 32'(bus.count), 32'd0);
        chk("rst_redir_addr", bus.imem_addr, 32'h0);
        chk("rst_redir_valid", 32'(bus.out_valid), 32'd0);
        step(1);
        chk("post_rst_push_pc", bus.out_pc, 32'h0);

        $display("scenario back-to-back redirects");
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h0000_1000;
        step(1);
        bus.redirect_pc = 32'h0000_2006;
        step(1);
        bus.redirect = 1'b0;
        chk("b2b_addr", bus.imem_addr, 32'h2004);
        chk("b2b_count", 32'(bus.count), 32'd0);
        step(1);
        chk("b2b_head_pc", bus.out_pc, 32'h2004);

        $display("scenario pc wrap");
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFC;
        step(1);
        bus.redirect = 1'b0;
        chk("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);
        step(2);
        chk("wrap_head_pc", bus.out_pc, 32'hFFFF_FFFC);
        chk("wrap_addr2", bus.imem_addr, 32'h4);
        bus.out_ready = 1'b1;
        step(1);
        bus.out_ready = 1'b0;
        chk("wrap_next_pc", bus.out_pc, 32'h0);

        $display("scenario random traffic");
        verbose = 1'b0;
        salt = $urandom;
        for (int i = 0; i < 3000; i++) begin
            bus.out_ready   = ($urandom_range(3) != 0);
            bus.redirect    = ($urandom_range(15) == 0);
            bus.redirect_pc = $urandom;
            rst             = ($urandom_range(127) == 0);
            step(1);
        end
        rst = 1'b0;
        bus.redirect = 1'b0;
        step(1);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries (power of two, >=2).
REQ-002 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 imem_addr  output  32  fetch address to instruction memory (combinational read).
REQ-006 imem_data  input  32  instruction word returned same cycle for imem_addr.
REQ-007 out_valid  output  1  head entry holds a valid instruction.
REQ-008 out_ready  input  1  consumer (core decode) accepts head entry this cycle.
REQ-009 out_instr  output  32  head entry instruction.
REQ-010 out_pc  output  32  head entry PC.
REQ-011 redirect  input  1  branch/jump taken; discard queue, refetch.
REQ-012 redirect_pc  input  32  new fetch address when redirect=1.
REQ-013 count  output  $clog2(DEPTH)+1  current occupancy, for debug/monitor.

Function
REQ-014 Register fetch_pc drives imem_addr directly at all times.
REQ-015 Push condition: count<DEPTH and redirect=0; {fetch_pc, imem_data} written at tail on the edge; fetch_pc += 4.
REQ-016 Pop condition: out_valid=1 and out_ready=1 and redirect=0; head advances one entry.
REQ-017 Push and pop in the same cycle: both occur, count unchanged.
REQ-018 Full (count=DEPTH): no push, fetch_pc holds, even if a pop occurs that cycle (no same-cycle bypass).
REQ-019 Empty (count=0): out_valid=0; out_instr/out_pc are don't-care; out_ready is ignored.
REQ-020 out_valid = (count!=0); out_instr/out_pc come from head storage, with no combinational path from imem_data.
REQ-021 Latency: an instruction fetched in cycle N is presented at the head no earlier than cycle N+1.
REQ-022 Redirect: on the edge, count <- 0, head/tail pointers <- 0, fetch_pc <- {redirect_pc[31:2],2'b00}; no push or pop that cycle.
REQ-023 Redirect has priority over push, pop and full; redirect while empty behaves identically.
REQ-024 Consecutive redirects: the last one wins; fetching resumes the cycle after redirect deasserts.
REQ-025 Pointers are log2(DEPTH) bits and wrap modulo DEPTH; count never exceeds DEPTH or underflows.
REQ-026 fetch_pc wraps modulo 2^32 (32'hFFFF_FFFC + 4 -> 0); no error is flagged.
REQ-027 Order is preserved: entries leave in push order with out_pc strictly +4 between consecutive entries absent redirect.

Reset
REQ-028 While rst=1 at an edge: fetch_pc <- RESET_PC, count <- 0, pointers <- 0; rst overrides redirect.
REQ-029 Reset values: out_valid=0, count=0, imem_addr=RESET_PC, out_instr/out_pc=0 (storage cleared).
REQ-030 Reset mid-operation discards all entries; the first post-reset push is RESET_PC in the first cycle with rst=0.

Structure
REQ-031 Package riscv_pkg holds XLEN=32, INSTR_W=32, the default RESET_PC and the fetch_entry_t typedef {pc, instr}.
REQ-032 Storage is a sub-module sync_fifo (parameter DEPTH, width of fetch_entry_t, push/pop/flush/count); fetch_queue adds PC generation and redirect control.

Verification
REQ-033 Reset release, out_ready=0, imem[i]=i: pushes at PCs 0,4,8,12; count=4 after 4 cycles; imem_addr holds 16; head pc=0, instr=0.
REQ-034 From full, out_ready=1 steady: one pop per cycle; out_pc sequence 0,4,8,... continuous with no gaps.
REQ-035 Full with a single-cycle pop: count 4->3, no push that cycle; next cycle push of PC 16, count back to 4.
REQ-036 redirect=1, redirect_pc=32'h0000_0103 with queue at count=3 and out_ready=1: next cycle count=0, out_valid=0, imem_addr=32'h100; following cycle head pc=32'h100.
REQ-037 rst asserted for one cycle while count=2 and redirect=1: count=0, imem_addr=RESET_PC, redirect ignored.
REQ-038 fetch_pc=32'hFFFF_FFFC via redirect: the push after it fetches address 0; out_pc sequence FFFF_FFFC, 0000_0000.
